// File: rtl/fir_root_pipe_if.sv
// fir_root_pipe_if
// Purpose: bundles the sample stream, the coefficient write port and the
//   result outputs of fir_root_pipe so they travel as one port.
// Signals:
//   Data_i, Valid_i, Ready_o          sample stream with backpressure
//   Coef_we, Coef_addr, Coef_wdata    coefficient bank write port
//   FIRout, Fir_valid_o               filter result and its "not yet taken" flag
//   ROOTout, Root_valid_o             floor(sqrt) of the taken result, 1-cycle pulse
// Modports:
//   master  sample source / controller side
//   slave   fir_root_pipe side
interface fir_root_pipe_if #(
  parameter int TAPS = 7,
  parameter int DW   = 8,
  parameter int CW   = 8,
  parameter int OW   = 16
);
  localparam int AW = $clog2(TAPS);

  logic [DW-1:0]   Data_i;
  logic            Valid_i;
  logic            Ready_o;
  logic            Coef_we;
  logic [AW-1:0]   Coef_addr;
  logic [CW-1:0]   Coef_wdata;
  logic [OW-1:0]   FIRout;
  logic            Fir_valid_o;
  logic [OW/2-1:0] ROOTout;
  logic            Root_valid_o;

  modport master (
    output Data_i, Valid_i, Coef_we, Coef_addr, Coef_wdata,
    input  Ready_o, FIRout, Fir_valid_o, ROOTout, Root_valid_o
  );

  modport slave (
    input  Data_i, Valid_i, Coef_we, Coef_addr, Coef_wdata,
    output Ready_o, FIRout, Fir_valid_o, ROOTout, Root_valid_o
  );
endinterface

// File: rtl/fir_root_pipe.sv
// fir_root_pipe
// Purpose: TAPS-tap unsigned FIR filter with a writable coefficient bank and a
//   valid/ready sample input, followed by an iterative restoring square root
//   of each filter result (one root bit per cycle).
// Ports:
//   Clk   rising-edge clock
//   Rst   asynchronous active-high reset
//   bus   fir_root_pipe_if.slave: Data_i/Valid_i/Ready_o sample stream,
//         Coef_we/Coef_addr/Coef_wdata coefficient writes,
//         FIRout/Fir_valid_o filter result, ROOTout/Root_valid_o root result
// Configuration:
//   FIRROOT_SAT_EN  defined: output limiting saturates at 2^OW-1
//                   undefined: output limiting keeps the low OW bits
module fir_root_pipe #(
  parameter int TAPS  = 7,
  parameter int DW    = 8,
  parameter int CW    = 8,
  parameter int OW    = 16,
  parameter int SHIFT = 0
) (
  input  logic           Clk,
  input  logic           Rst,
  fir_root_pipe_if.slave bus
);
  localparam int AW   = $clog2(TAPS);
  localparam int ACCW = DW + CW + $clog2(TAPS);
  localparam int LW   = (ACCW > OW) ? ACCW : OW;
  localparam int HW   = OW / 2;
  localparam int RW   = HW + 3;
  localparam int CNTW = (HW > 1) ? $clog2(HW) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [DW-1:0]   x_q    [TAPS];
  logic [CW-1:0]   coef_q [TAPS];
  logic [DW-1:0]   xNew   [TAPS];
  logic [ACCW-1:0] acc;
  logic [OW-1:0]   firLim;
  logic [OW-1:0]   firOut_q;
  logic            firValid_q, firValid_d;
  logic [1:0]      state_q, state_d;
  logic [OW-1:0]   rad_q;
  logic [RW-1:0]   rem_q;
  logic [RW-1:0]   remShift, trial, remNext;
  logic [HW-1:0]   root_q, rootNext, rootOut_q;
  logic [CNTW-1:0] cnt_q;
  logic            ready, accept, lastIter;

  // The result register is a one-entry buffer: it may be refilled whenever
  // it is empty or the root stage is about to take its current content.
  assign ready    = !firValid_q || (state_q == IDLE);
  assign accept   = bus.Valid_i && ready;
  assign lastIter = (cnt_q == CNTW'(HW - 1));

  // Sum over the delay line as it will look after this edge's shift, using the
  // coefficient bank before any same-edge write.
  always_comb begin
    xNew[0] = bus.Data_i;
    for (int k = 1; k < TAPS; k++) xNew[k] = x_q[k-1];
    acc = '0;
    for (int k = 0; k < TAPS; k++)
      acc = acc + ACCW'(coef_q[k]) * ACCW'(xNew[k]);
  end

`ifdef FIRROOT_SAT_EN
  logic [LW-1:0] accShift;
  assign accShift = LW'(acc) >> SHIFT;
  assign firLim   = (accShift > LW'({OW{1'b1}})) ? {OW{1'b1}} : accShift[OW-1:0];
`else
  assign firLim = OW'(LW'(acc) >> SHIFT);
`endif

  // A new accept keeps the buffer full even while IDLE hands the old value on.
  always_comb begin
    firValid_d = firValid_q;
    if (accept)                firValid_d = 1'b1;
    else if (state_q == IDLE)  firValid_d = 1'b0;
  end

  // Delay line, coefficient bank and result buffer.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int k = 0; k < TAPS; k++) begin
        x_q[k]    <= '0;
        coef_q[k] <= '0;
      end
      firOut_q   <= '0;
      firValid_q <= 1'b0;
    end else begin
      if (accept) begin
        for (int k = 0; k < TAPS; k++) x_q[k] <= xNew[k];
        firOut_q <= firLim;
      end
      // Addresses at or above TAPS match no entry, so such writes are dropped.
      for (int k = 0; k < TAPS; k++)
        if (bus.Coef_we && (bus.Coef_addr == AW'(k))) coef_q[k] <= bus.Coef_wdata;
      firValid_q <= firValid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (firValid_q) state_d = CALC;
      CALC:    if (lastIter)   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One restoring step: bring down the next two radicand bits and try to
  // subtract 4*root+1; success appends a 1 to the root.
  always_comb begin
    remShift = (rem_q << 2) | RW'(rad_q[OW-1:OW-2]);
    trial    = (RW'(root_q) << 2) | RW'(1);
    remNext  = remShift;
    rootNext = root_q << 1;
    if (remShift >= trial) begin
      remNext  = remShift - trial;
      rootNext = (root_q << 1) | HW'(1);
    end
  end

  // Root datapath; the radicand shifts left so its top pair is always next.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= IDLE;
      rad_q     <= '0;
      rem_q     <= '0;
      root_q    <= '0;
      rootOut_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (firValid_q) begin
            rad_q  <= firOut_q;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
          end
        end
        CALC: begin
          rad_q  <= rad_q << 2;
          rem_q  <= remNext;
          root_q <= rootNext;
          cnt_q  <= cnt_q + CNTW'(1);
          if (lastIter) rootOut_q <= rootNext;
        end
        default: ;
      endcase
    end
  end

  assign bus.Ready_o      = ready;
  assign bus.FIRout       = firOut_q;
  assign bus.Fir_valid_o  = firValid_q;
  assign bus.ROOTout      = rootOut_q;
  assign bus.Root_valid_o = (state_q == DONE);
endmodule
